// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: captures an N-point frame in bit-reversed order and replays it in natural order.
// Define FFT_REORDER_OVF_CNT_EN to add the saturating dropped-frame counter output ovf_cnt.
module fft_bitrev_reorder #(
  parameter int LOG2N = 5,
  parameter int DW    = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [LOG2N-1:0]     out_idx,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 ovf,
  output logic                 busy
`ifdef FFT_REORDER_OVF_CNT_EN
  ,
  output logic [15:0]          ovf_cnt
`endif
);

  localparam int N = 1 << LOG2N;

  localparam logic [1:0] B_EMPTY    = 2'd0;
  localparam logic [1:0] B_FILLING  = 2'd1;
  localparam logic [1:0] B_FULL     = 2'd2;
  localparam logic [1:0] B_DRAINING = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FILL = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  localparam logic [LOG2N-1:0] IDX0     = '0;
  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Address = {bank, sample index}; each entry holds {re, im}.
  logic [2*DW-1:0]    mem [2*N];

  logic [1:0][1:0]    bstate;
  logic [1:0]         wstate;
  logic [0:0]         rstate;
  logic               wbank;
  logic               rbank;
  logic [LOG2N-1:0]   wcnt;

  logic               hs;
  logic               release_now;
  logic               sof_hit;
  logic [1:0]         free;
  logic               any_free;
  logic               cbank;
  logic               drop;
  logic               we;
  logic [LOG2N:0]     waddr;
  logic               ld;
  logic [LOG2N:0]     raddr;

  assign hs          = out_valid & out_ready;
  assign release_now = hs & out_eof;
  assign sof_hit     = in_valid & in_sof;

  // A draining bank whose last sample leaves this cycle can be reclaimed on the same edge.
  assign free[0]  = (bstate[0] == B_EMPTY) | ((bstate[0] == B_DRAINING) & release_now & (rbank == 1'b0));
  assign free[1]  = (bstate[1] == B_EMPTY) | ((bstate[1] == B_DRAINING) & release_now & (rbank == 1'b1));
  assign any_free = |free;
  assign cbank    = (bstate[0] == B_EMPTY) ? 1'b0 :
                    (bstate[1] == B_EMPTY) ? 1'b1 :
                    (free[0] ? 1'b0 : 1'b1);
  assign drop     = (wstate != W_FILL) & sof_hit & ~any_free;

  assign busy = (bstate[0] != B_EMPTY) | (bstate[1] != B_EMPTY);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    we    = 1'b0;
    waddr = {wbank, IDX0};
    if (wstate == W_FILL) begin
      if (sof_hit) begin
        we    = 1'b1;
        waddr = {wbank, IDX0};
      end else if (in_valid) begin
        we    = 1'b1;
        waddr = {wbank, bitrev(wcnt)};
      end
    end else if (sof_hit && any_free) begin
      we    = 1'b1;
      waddr = {cbank, IDX0};
    end
  end

  always_comb begin
    ld    = 1'b0;
    raddr = {rbank, out_idx + LOG2N'(1)};
    if (rstate == R_DRAIN) begin
      if (!out_valid) begin
        ld    = 1'b1;
        raddr = {rbank, IDX0};
      end else if (hs) begin
        if (!out_eof) begin
          ld = 1'b1;
        end else if (bstate[~rbank] == B_FULL) begin
          ld    = 1'b1;
          raddr = {~rbank, IDX0};
        end
      end
    end
  end

  // NOTE: sample storage carries no reset; bank state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {in_re, in_im};
  end

  // NOTE: state is updated with non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate    <= '0;
      wstate    <= W_IDLE;
      rstate    <= R_IDLE;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= drop;

      if (rstate == R_IDLE) begin
        if (bstate[0] == B_FULL) begin
          rbank     <= 1'b0;
          bstate[0] <= B_DRAINING;
          rstate    <= R_DRAIN;
        end else if (bstate[1] == B_FULL) begin
          rbank     <= 1'b1;
          bstate[1] <= B_DRAINING;
          rstate    <= R_DRAIN;
        end
      end

      if (ld) begin
        out_valid         <= 1'b1;
        {out_re, out_im}  <= mem[raddr];
        out_idx           <= raddr[LOG2N-1:0];
        out_sof           <= (raddr[LOG2N-1:0] == IDX0);
        out_eof           <= (raddr[LOG2N-1:0] == IDX_LAST);
        rbank             <= raddr[LOG2N];
      end

      if (release_now) begin
        bstate[rbank] <= B_EMPTY;
        if (bstate[~rbank] == B_FULL) begin
          bstate[~rbank] <= B_DRAINING;
        end else begin
          out_valid <= 1'b0;
          rstate    <= R_IDLE;
        end
      end

      // Write side runs last so a same-edge reclaim overrides the release to EMPTY.
      if (wstate == W_FILL) begin
        if (sof_hit) begin
          wcnt <= LOG2N'(1);
        end else if (in_valid) begin
          if (wcnt == IDX_LAST) begin
            bstate[wbank] <= B_FULL;
            wstate        <= W_IDLE;
            wcnt          <= '0;
          end else begin
            wcnt <= wcnt + LOG2N'(1);
          end
        end
      end else if (sof_hit) begin
        if (any_free) begin
          wbank         <= cbank;
          bstate[cbank] <= B_FILLING;
          wcnt          <= LOG2N'(1);
          wstate        <= W_FILL;
        end else begin
          wstate <= W_DROP;
        end
      end
    end
  end

`ifdef FFT_REORDER_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: random frames checked against a natural-order reference built from plain index arithmetic.
// Builds with or without FFT_REORDER_OVF_CNT_EN.
module tb_fft_bitrev_reorder;

  localparam int LOG2N = 5;
  localparam int DW    = 17;
  localparam int N     = 1 << LOG2N;

  typedef struct packed {
    logic [N-1:0][DW-1:0] re;
    logic [N-1:0][DW-1:0] im;
  } frame_t;

  typedef struct packed {
    logic [DW-1:0]    re;
    logic [DW-1:0]    im;
    logic [LOG2N-1:0] idx;
    logic             sof;
    logic             eof;
  } samp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [LOG2N-1:0]     out_idx;
  logic                 out_sof;
  logic                 out_eof;
  logic                 ovf;
  logic                 busy;
`ifdef FFT_REORDER_OVF_CNT_EN
  logic [15:0]          ovf_cnt;
`endif

  int    compared   = 0;
  int    mismatched = 0;
  int    ovf_seen   = 0;
  int    rx_count   = 0;
  samp_t exp_q[$];

  fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .ovf       (ovf),
    .busy      (busy)
`ifdef FFT_REORDER_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ovf === 1'b1) ovf_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  // Bit reversal by repeated halving, independent of any bit slicing.
  function automatic int rev_idx(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Input position k carries bin rev(k); natural output bin i is therefore input position rev(i).
  function automatic void model_frame(input frame_t f);
    samp_t s;
    for (int i = 0; i < N; i++) begin
      s.re  = f.re[rev_idx(i)];
      s.im  = f.im[rev_idx(i)];
      s.idx = LOG2N'(i);
      s.sof = (i == 0);
      s.eof = (i == N - 1);
      exp_q.push_back(s);
    end
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f.re[k] = DW'($urandom);
      f.im[k] = DW'($urandom);
    end
    return f;
  endfunction

  task automatic send_frame(input frame_t f, input int nsamp, input int gap);
    for (int k = 0; k < nsamp; k++) begin
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_re    = f.re[k];
      in_im    = f.im[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Records accepted output samples; also notes changes while stalled and idle gaps inside the stream.
  task automatic capture(input int n, input int pct, output samp_t got[$],
                         output int unstable, output int bubbles, output bit timed_out);
    samp_t cur, prev;
    bit    prev_stall = 0;
    bit    started    = 0;
    got = {}; unstable = 0; bubbles = 0; timed_out = 0; prev = '0;
    for (int cyc = 0; got.size() < n; cyc++) begin
      if (cyc > n * 20 + 200) begin timed_out = 1; break; end
      @(negedge clk);
      cur = {out_re, out_im, out_idx, out_sof, out_eof};
      if (prev_stall && (out_valid !== 1'b1 || cur !== prev)) unstable++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got.push_back(cur);
        rx_count++;
        started = 1;
      end else if (started && out_valid !== 1'b1) begin
        bubbles++;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev = cur;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 99) < pct);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    compared++;
    if ({out_re, out_im} !== '0) begin mismatched++; $display("FAIL reset_data: got %h/%h expected 0/0", out_re, out_im); end
    compared++;
    if (out_idx !== '0) begin mismatched++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    compared++;
    if ({out_sof, out_eof, ovf} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got sof/eof/ovf=%b%b%b expected 000", out_sof, out_eof, ovf); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef FFT_REORDER_OVF_CNT_EN
    compared++;
    if (ovf_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    frame_t f;
    samp_t  got[$];
    int     unst, bub, lat, ovf0;
    bit     to;
    for (int k = 0; k < N; k++) begin
      f.re[k] = DW'(k);
      f.im[k] = DW'(-k);
    end
    exp_q = {};
    model_frame(f);
    ovf0 = ovf_seen;
    out_ready = 1'b1;
    lat = 0;
    fork
      begin
        send_frame(f, N, 0);
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      end
      capture(N, 100, got, unst, bub, to);
    join
    compared++;
    if (to) begin mismatched++; $display("FAIL single_timeout: got %0d samples expected %0d", got.size(), N); end
    compared++;
    if (lat != 2) begin mismatched++; $display("FAIL single_latency: got %0d cycles expected 2", lat); end
    compared++;
    if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL single_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got[i] !== exp_q[i]) begin mismatched++; $display("FAIL single_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
    if (got.size() == N) begin
      compared++;
      if ({got[1].re, got[2].re, got[31].re} !== {DW'(16), DW'(8), DW'(31)})
        begin mismatched++; $display("FAIL single_known_bins: got %0d,%0d,%0d expected 16,8,31", got[1].re, got[2].re, got[31].re); end
    end
    compared++;
    if (ovf_seen != ovf0) begin mismatched++; $display("FAIL single_ovf: got %0d pulses expected 0", ovf_seen - ovf0); end
  endtask

  // A and B go in back-to-back; C starts after one idle cycle so its first sample lands on A's final handshake.
  task automatic test_back_to_back();
    frame_t fa, fb, fc;
    samp_t  got[$];
    int     unst, bub, ovf0;
    bit     to;
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    exp_q = {};
    model_frame(fa); model_frame(fb); model_frame(fc);
    ovf0 = ovf_seen;
    out_ready = 1'b1;
    fork
      begin send_frame(fa, N, 0); send_frame(fb, N, 1); send_frame(fc, N, 0); end
      capture(3 * N, 100, got, unst, bub, to);
    join
    compared++;
    if (to) begin mismatched++; $display("FAIL b2b_timeout: got %0d samples expected %0d", got.size(), 3 * N); end
    compared++;
    if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL b2b_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got[i] !== exp_q[i]) begin mismatched++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
    compared++;
    if (bub != 0) begin mismatched++; $display("FAIL b2b_bubbles: got %0d expected 0", bub); end
    compared++;
    if (ovf_seen != ovf0) begin mismatched++; $display("FAIL b2b_ovf: got %0d pulses expected 0", ovf_seen - ovf0); end
  endtask

  task automatic test_overflow();
    frame_t fa, fb, fc;
    samp_t  got[$];
    int     unst, bub, ovf0, late;
    bit     to;
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    exp_q = {};
    model_frame(fa); model_frame(fb);
    ovf0 = ovf_seen;
    out_ready = 1'b0;
    send_frame(fa, N, 0); send_frame(fb, N, 0); send_frame(fc, N, 3);
    compared++;
    if (ovf_seen - ovf0 != 1) begin mismatched++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_seen - ovf0); end
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL ovf_busy: got %b expected 1", busy); end
`ifdef FFT_REORDER_OVF_CNT_EN
    compared++;
    if (ovf_cnt !== 16'd1) begin mismatched++; $display("FAIL ovf_cnt: got %0d expected 1", ovf_cnt); end
`endif
    out_ready = 1'b1;
    capture(2 * N, 100, got, unst, bub, to);
    compared++;
    if (to) begin mismatched++; $display("FAIL ovf_timeout: got %0d samples expected %0d", got.size(), 2 * N); end
    compared++;
    if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL ovf_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got[i] !== exp_q[i]) begin mismatched++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
    late = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) late++; end
    compared++;
    if (late != 0) begin mismatched++; $display("FAIL ovf_dropped_frame_out: got %0d valid cycles expected 0", late); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL ovf_idle_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
  endtask

  // A new frame starts only while at most one earlier frame is still undelivered, so none is dropped.
  task automatic test_random_ready();
    frame_t fr[4];
    samp_t  got[$];
    int     unst, bub, ovf0;
    bit     to;
    exp_q = {};
    for (int s = 0; s < 4; s++) begin fr[s] = rand_frame(); model_frame(fr[s]); end
    ovf0 = ovf_seen;
    rx_count = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int s = 0; s < 4; s++) begin
          for (int w = 0; w < 5000 && (s - rx_count / N) > 1; w++) begin @(posedge clk); #1; end
          send_frame(fr[s], N, $urandom_range(0, 3));
        end
      end
      capture(4 * N, 50, got, unst, bub, to);
    join
    out_ready = 1'b1;
    compared++;
    if (to) begin mismatched++; $display("FAIL rand_timeout: got %0d samples expected %0d", got.size(), 4 * N); end
    compared++;
    if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL rand_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
    compared++;
    if (unst != 0) begin mismatched++; $display("FAIL rand_stall_stability: got %0d changes expected 0", unst); end
    compared++;
    if (ovf_seen != ovf0) begin mismatched++; $display("FAIL rand_ovf: got %0d pulses expected 0", ovf_seen - ovf0); end
  endtask

  task automatic test_restart();
    frame_t f1, f2;
    samp_t  got[$];
    int     unst, bub, ovf0, late;
    bit     to;
    f1 = rand_frame(); f2 = rand_frame();
    exp_q = {};
    model_frame(f2);
    ovf0 = ovf_seen;
    out_ready = 1'b1;
    fork
      begin send_frame(f1, 10, 0); send_frame(f2, N, 0); end
      capture(N, 100, got, unst, bub, to);
    join
    compared++;
    if (to) begin mismatched++; $display("FAIL restart_timeout: got %0d samples expected %0d", got.size(), N); end
    compared++;
    if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL restart_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got[i] !== exp_q[i]) begin mismatched++; $display("FAIL restart_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
    late = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) late++; end
    compared++;
    if (late != 0 || ovf_seen != ovf0) begin mismatched++; $display("FAIL restart_extra: got %0d extra valid cycles, %0d ovf pulses expected 0/0", late, ovf_seen - ovf0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    frame_t f1, f2;
    samp_t  got[$];
    int     unst, bub, w;
    bit     to;
    f1 = rand_frame(); f2 = rand_frame();
    out_ready = 1'b1;
    send_frame(f1, N, 0);
    w = 0;
    @(negedge clk);
    while (!(out_valid === 1'b1 && out_idx === LOG2N'(12)) && w < 100) begin @(negedge clk); w++; end
    compared++;
    if (w >= 100) begin mismatched++; $display("FAIL midrst_reach_idx12: got idx %0d valid %b expected idx 12 valid 1", out_idx, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, out_re, out_im, out_idx, out_sof, out_eof, ovf, busy} !== '0)
      begin mismatched++; $display("FAIL midrst_outputs: got valid=%b re=%h im=%h idx=%0d sof=%b eof=%b ovf=%b busy=%b expected all 0",
                                   out_valid, out_re, out_im, out_idx, out_sof, out_eof, ovf, busy); end
`ifdef FFT_REORDER_OVF_CNT_EN
    compared++;
    if (ovf_cnt !== 16'd0) begin mismatched++; $display("FAIL midrst_ovf_cnt: got %0d expected 0", ovf_cnt); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q = {};
    model_frame(f2);
    fork
      send_frame(f2, N, 0);
      capture(N, 100, got, unst, bub, to);
    join
    compared++;
    if (to) begin mismatched++; $display("FAIL midrst_timeout: got %0d samples expected %0d", got.size(), N); end
    compared++;
    if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL midrst_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      compared++;
      if (got[i] !== exp_q[i]) begin mismatched++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_random_ready();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
